dictionary_bank_pp: RTL and testbench

Double-buffered dictionary-decode stage for the dictionary datapath. A dictionary of up to DEPTH values is loaded as a stream while lookups against the previously loaded dictionary proceed in parallel. Each lookup id returns its value together with pass-through serial, keep and last sidebands. Lookups whose id lies outside the loaded entry count are flagged. It sits between the dictionary-page parser (values) and the index decoder (ids), feeding the column reassembly stage.

---
 rtl/dictionary_bank_pp_pkg.sv | 9 +
 rtl/dictionary_bank_pp_ram.sv | 21 ++
 rtl/dictionary_bank_pp.sv | 104 ++++++++++
 tb/tb_dictionary_bank_pp.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dictionary_bank_pp_pkg.sv
// dictionary_bank_pp_pkg: default geometry and bank helper for the dictionary bank stage
package dictionary_bank_pp_pkg;
  localparam int DEF_VALUE_WIDTH = 32;
  localparam int DEF_DEPTH = 4096;
  localparam int DEF_SERIAL_WIDTH = 16;
  function automatic logic other_bank(input logic b);
    return ~b;
  endfunction
endpackage

// File: rtl/dictionary_bank_pp_ram.sv
// ReadyRAM: simple dual-port RAM, synchronous write, registered read gated by re
module ReadyRAM #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter STYLE = "ultra"
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  (* ram_style = STYLE *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // write port and read port; read data holds while re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dictionary_bank_pp.sv
// dictionary_bank_pp: double-buffered dictionary load with one-cycle lookup and oob flag
module dictionary_bank_pp
  import dictionary_bank_pp_pkg::*;
#(
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SERIAL_WIDTH = DEF_SERIAL_WIDTH,
  parameter RAM_STYLE = "ultra",
  localparam int ID_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH = ID_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_value_valid,
  output logic                    in_value_ready,
  input  logic [VALUE_WIDTH-1:0]  in_value_data,
  input  logic                    in_value_last,
  input  logic                    in_id_valid,
  output logic                    in_id_ready,
  input  logic [ID_WIDTH-1:0]     in_id_id,
  input  logic [SERIAL_WIDTH-1:0] in_id_serial,
  input  logic                    in_id_keep,
  input  logic                    in_id_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [VALUE_WIDTH-1:0]  out_value,
  output logic [SERIAL_WIDTH-1:0] out_serial,
  output logic                    out_keep,
  output logic                    out_last,
  output logic                    out_oob,
  output logic                    overflow
);
  logic [1:0] filled;
  logic [CNT_WIDTH-1:0] count [2];
  logic wbank, rbank, draining;
  logic [ID_WIDTH-1:0] waddr;
  logic [VALUE_WIDTH-1:0] rdata;
  logic val_fire, wrap, advance, id_fire, rel;
  assign in_value_ready = !filled[wbank];
  assign val_fire = in_value_valid && in_value_ready;
  assign wrap = val_fire && (in_value_last || &waddr);
  assign advance = !out_valid || out_ready;
  assign in_id_ready = filled[rbank] && !draining && advance;
  assign id_fire = in_id_valid && in_id_ready;
  assign rel = out_valid && out_ready && out_last;
  assign out_value = out_valid && !out_oob ? rdata : '0;
  ReadyRAM #(
    .DATA_WIDTH(VALUE_WIDTH),
    .ADDR_WIDTH(ID_WIDTH + 1),
    .STYLE(RAM_STYLE)
  ) u_ram (
    .clk(clk),
    .we(val_fire),
    .waddr({wbank, waddr}),
    .wdata(in_value_data),
    .re(advance),
    .raddr({rbank, in_id_id}),
    .rdata(rdata)
  );
  // bank bookkeeping: fill completes a bank, release of the read bank frees it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filled <= '0;
      count[0] <= '0;
      count[1] <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      waddr <= '0;
      draining <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= val_fire && &waddr && !in_value_last;
      if (val_fire) waddr <= in_value_last ? '0 : waddr + ID_WIDTH'(1);
      if (wrap) begin
        filled[wbank] <= 1'b1;
        count[wbank] <= CNT_WIDTH'(waddr) + CNT_WIDTH'(1);
        wbank <= other_bank(wbank);
      end
      if (rel) begin
        filled[rbank] <= 1'b0;
        rbank <= other_bank(rbank);
        draining <= 1'b0;
      end else if (id_fire && in_id_last) draining <= 1'b1;
    end
  end
  // result register: advances with the RAM read, holds while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_serial <= '0;
      out_keep <= 1'b0;
      out_last <= 1'b0;
      out_oob <= 1'b0;
    end else if (advance) begin
      out_valid <= id_fire;
      if (id_fire) begin
        out_serial <= in_id_serial;
        out_keep <= in_id_keep;
        out_last <= in_id_last;
        out_oob <= CNT_WIDTH'(in_id_id) >= count[rbank];
      end
    end
  end
endmodule

// File: tb/tb_dictionary_bank_pp.sv
// tb_dictionary_bank_pp: randomized scoreboard bench against a dictionary-list reference model
module tb_dictionary_bank_pp;
  localparam int DEPTH = 8;
  localparam int VW = 32;
  localparam int SW = 16;
  localparam int IW = 3;
  typedef struct {
    logic [VW-1:0] v;
    logic [SW-1:0] s;
    logic k;
    logic l;
    logic o;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic in_value_valid = 0, in_value_ready, in_value_last = 0;
  logic [VW-1:0] in_value_data = 0;
  logic in_id_valid = 0, in_id_ready, in_id_keep = 0, in_id_last = 0;
  logic [IW-1:0] in_id_id = 0;
  logic [SW-1:0] in_id_serial = 0;
  logic out_valid, out_ready = 1, out_keep, out_last, out_oob, overflow;
  logic [VW-1:0] out_value;
  logic [SW-1:0] out_serial;
  int checks = 0, errors = 0, vstall = 0, rdy_mode = 0, pidx = 0;
  exp_t sb[$];
  int dict_len[$];
  logic [VW-1:0] dict_vals[$];
  logic [VW-1:0] build[$];
  int id_list[$];
  logic exp_ovf = 0, held_v = 0;
  logic [51:0] held;
  logic [3:0] pat = 4'b1001;
  dictionary_bank_pp #(.VALUE_WIDTH(VW), .DEPTH(DEPTH), .SERIAL_WIDTH(SW), .RAM_STYLE("ultra")) dut (
    .clk(clk), .rst_n(rst_n),
    .in_value_valid(in_value_valid), .in_value_ready(in_value_ready),
    .in_value_data(in_value_data), .in_value_last(in_value_last),
    .in_id_valid(in_id_valid), .in_id_ready(in_id_ready), .in_id_id(in_id_id),
    .in_id_serial(in_id_serial), .in_id_keep(in_id_keep), .in_id_last(in_id_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_serial(out_serial), .out_keep(out_keep), .out_last(out_last),
    .out_oob(out_oob), .overflow(overflow)
  );
  always #5 clk = ~clk;
  // output backpressure generator: always ready, random, or the 1,0,0,1 pattern
  initial forever begin
    @(posedge clk);
    #2;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(1)) : pat[3 - (pidx % 4)];
    pidx++;
  end
  // reference model and monitor: observe handshakes mid-cycle, check results and flags
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      dict_len.delete();
      dict_vals.delete();
      build.delete();
      exp_ovf = 0;
      held_v = 0;
    end else begin
      if (exp_ovf || overflow) begin
        checks++;
        if (overflow !== exp_ovf) begin
          errors++;
          $display("FAIL overflow: got %b want %b", overflow, exp_ovf);
        end
      end
      exp_ovf = 0;
      if (held_v) begin
        checks++;
        if ({out_valid, out_value, out_serial, out_keep, out_last, out_oob} !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h want %h", {out_valid, out_value, out_serial, out_keep, out_last, out_oob}, held);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_id_ready !== 1'b0) begin
          errors++;
          $display("FAIL id_ready_stall: got %b want 0", in_id_ready);
        end
      end
      held_v = out_valid && !out_ready;
      held = {out_valid, out_value, out_serial, out_keep, out_last, out_oob};
      if (in_value_valid && !in_value_ready) vstall++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got value %0d serial %h, want nothing", out_value, out_serial);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_value !== e.v || out_serial !== e.s || out_keep !== e.k || out_last !== e.l || out_oob !== e.o) begin
            errors++;
            $display("FAIL result: got v=%0d s=%h k=%b l=%b oob=%b want v=%0d s=%h k=%b l=%b oob=%b",
                     out_value, out_serial, out_keep, out_last, out_oob, e.v, e.s, e.k, e.l, e.o);
          end
          if (e.l && dict_len.size() > 0) begin
            for (int i = 0; i < dict_len[0]; i++) void'(dict_vals.pop_front());
            void'(dict_len.pop_front());
          end
        end
      end
      if (in_value_valid && in_value_ready) begin
        exp_ovf = build.size() == DEPTH - 1 && !in_value_last;
        build.push_back(in_value_data);
        if (in_value_last || build.size() == DEPTH) begin
          dict_len.push_back(build.size());
          foreach (build[i]) dict_vals.push_back(build[i]);
          build.delete();
        end
      end
      if (in_id_valid && in_id_ready) begin
        if (dict_len.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL id_accept: got accept with no loaded dictionary, want stall");
        end else begin
          exp_t e;
          e.o = int'(in_id_id) >= dict_len[0];
          e.v = e.o ? '0 : dict_vals[in_id_id];
          e.s = in_id_serial;
          e.k = in_id_keep;
          e.l = in_id_last;
          sb.push_back(e);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask
  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic ok;
      in_value_valid = 1;
      in_value_data = VW'(base + i);
      in_value_last = i == n - 1;
      forever begin
        @(negedge clk);
        ok = in_value_ready;
        @(posedge clk);
        #2;
        if (ok) break;
        if (++t > 300) begin
          errors++;
          $display("FAIL value_timeout: got no in_value_ready, want accept");
          break;
        end
      end
      in_value_valid = 0;
      if ($urandom_range(2) == 0) begin
        @(posedge clk);
        #2;
      end
    end
  endtask
  task automatic lookup(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic ok;
      in_id_valid = 1;
      in_id_id = id_list.size() > 0 ? IW'(id_list.pop_front()) : IW'($urandom_range(DEPTH - 1));
      in_id_serial = SW'($urandom);
      in_id_keep = 1'($urandom_range(1));
      in_id_last = with_last && i == n - 1;
      forever begin
        @(negedge clk);
        ok = in_id_ready;
        @(posedge clk);
        #2;
        if (ok) break;
        if (++t > 300) begin
          errors++;
          $display("FAIL id_timeout: got no in_id_ready, want accept");
          break;
        end
      end
      in_id_valid = 0;
      in_id_last = 0;
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #2;
      end
    end
  endtask
  task automatic drain;
    int t = 0;
    while (sb.size() > 0 || out_valid) begin
      @(posedge clk);
      #2;
      if (++t > 300) begin
        errors++;
        $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
        break;
      end
    end
  endtask
  initial begin
    int ns[6];
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_oob", 32'(out_oob), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_value_ready", 32'(in_value_ready), 1);
    chk("rst_id_ready", 32'(in_id_ready), 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    load(5, 10);
    id_list = '{0, 4, 2};
    lookup(3, 1);
    drain();
    vstall = 0;
    fork
      begin
        load(2, 1);
        load(3, 7);
      end
      begin
        lookup(3, 1);
        id_list = '{2};
        lookup(1, 1);
      end
    join
    drain();
    chk("pingpong_no_stall", 32'(vstall), 0);
    load(3, 5);
    id_list = '{3, 7, 0};
    lookup(3, 1);
    drain();
    load(10, 100);
    id_list = '{7, 0};
    lookup(8, 1);
    id_list = '{0, 1, 2};
    lookup(3, 1);
    drain();
    rdy_mode = 2;
    pidx = 0;
    load(4, 40);
    lookup(6, 1);
    drain();
    rdy_mode = 1;
    foreach (ns[r]) ns[r] = $urandom_range(12, 1);
    fork
      foreach (ns[r]) load(ns[r], $urandom_range(1000));
      foreach (ns[r]) repeat (ns[r] > DEPTH ? 2 : 1) lookup($urandom_range(6, 1), 1);
    join
    drain();
    rdy_mode = 0;
    load(3, 200);
    load(2, 300);
    @(negedge clk);
    chk("both_full_value_ready", 32'(in_value_ready), 0);
    @(posedge clk);
    #2;
    lookup(2, 0);
    rst_n = 0;
    @(posedge clk);
    #2;
    rst_n = 1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_value_ready", 32'(in_value_ready), 1);
    chk("midrst_id_ready", 32'(in_id_ready), 0);
    chk("midrst_out_value", out_value, 0);
    @(posedge clk);
    #2;
    load(2, 77);
    lookup(2, 1);
    drain();
    @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 0);
    chk("final_dicts_empty", 32'(dict_len.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish");
    $fatal(1, "watchdog");
  end
endmodule
